mem_io_ctrl: RTL

Memory/I-O bridge between the SLC-3 datapath and the external asynchronous SRAM. It consumes the datapath's MAR/MDR and the control unit's read/write strobes. It produces the datapath's MDR_In word and a ready flag R that gates the control FSM out of its memory wait states. Address IO_ADDR is memory-mapped I/O: reads return the switches, writes load a hex-display register.

---
 rtl/mem_io_ctrl_if.sv | 30 +++
 rtl/mem_io_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/mem_io_ctrl_if.sv
// Bus bundle between the SLC-3 datapath/control unit, the bridge and the external SRAM.
// The bridge takes the master modport; the datapath/SRAM side takes the slave modport.
interface mem_io_ctrl_if;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic        MEM_OE;
    logic        MEM_WE;
    logic [15:0] SW;
    logic [15:0] Data_from_SRAM;
    logic [15:0] Data_to_SRAM;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N;
    logic        SRAM_OE_N;
    logic        SRAM_WE_N;
    logic [15:0] MDR_In;
    logic        R;
    logic [15:0] HEX_DATA;

    modport master (
        input  MAR, MDR, MEM_OE, MEM_WE, SW, Data_from_SRAM,
        output Data_to_SRAM, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
               MDR_In, R, HEX_DATA
    );

    modport slave (
        output MAR, MDR, MEM_OE, MEM_WE, SW, Data_from_SRAM,
        input  Data_to_SRAM, SRAM_ADDR, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N,
               MDR_In, R, HEX_DATA
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// SLC-3 memory/I-O bridge: times SRAM strobes for WAIT_CYCLES cycles, maps IO_ADDR
// onto switches (read) and the hex-display register (write), and raises R when done.
module mem_io_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic          Clk,
    input  logic          Reset,
    mem_io_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] W_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_count;
    logic       r_isWrite;

    logic w_request;
    logic w_isIo;

    assign w_request = bus.MEM_OE | bus.MEM_WE;
    assign w_isIo    = (bus.MAR == IO_ADDR);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state          <= IDLE;
            r_count          <= 4'd0;
            r_isWrite        <= 1'b0;
            bus.MDR_In       <= 16'h0000;
            bus.HEX_DATA     <= 16'h0000;
            bus.R            <= 1'b0;
            bus.SRAM_CE_N    <= 1'b1;
            bus.SRAM_OE_N    <= 1'b1;
            bus.SRAM_WE_N    <= 1'b1;
            bus.Data_to_SRAM <= 16'h0000;
            bus.SRAM_ADDR    <= 20'h00000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_request) begin
                        if (w_isIo) begin
                            if (bus.MEM_WE) bus.HEX_DATA <= bus.MDR;
                            else            bus.MDR_In   <= bus.SW;
                            bus.R   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            // Write wins when both requests are raised together.
                            r_isWrite        <= bus.MEM_WE;
                            bus.SRAM_ADDR    <= {4'b0000, bus.MAR};
                            bus.Data_to_SRAM <= bus.MDR;
                            r_count          <= W_LOAD;
                            bus.SRAM_CE_N    <= 1'b0;
                            bus.SRAM_OE_N    <= bus.MEM_WE;
                            bus.SRAM_WE_N    <= ~bus.MEM_WE;
                            r_state          <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (r_count == 4'd0) begin
                        if (!r_isWrite) bus.MDR_In <= bus.Data_from_SRAM;
                        bus.SRAM_CE_N <= 1'b1;
                        bus.SRAM_OE_N <= 1'b1;
                        bus.SRAM_WE_N <= 1'b1;
                        bus.R         <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                DONE: begin
                    // Hold R until control drops both requests, so one request means one access.
                    if (!bus.MEM_OE && !bus.MEM_WE) begin
                        bus.R   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
